// File: rtl/fec_pkg.sv
// Shared types for the row-serial 2D-parity FEC decoder.
package fec_pkg;

  // Widest row/column index the status struct can carry; narrower decoders
  // use the low bits only.
  localparam int IDX_MAX_W = 8;

  typedef enum logic [1:0] {
    LOAD,
    COLP,
    CHECK,
    DRAIN
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    DATA1,
    PAR1,
    UNCORR
  } err_class_e;

  typedef struct packed {
    logic                 detected;
    logic                 corrected;
    logic                 uncorrectable;
    logic [IDX_MAX_W-1:0] row;
    logic [IDX_MAX_W-1:0] col;
  } status_t;

endpackage

// File: rtl/fec_syndrome_classify.sv
// Classifies row/column parity syndromes into an error class and locates a
// single data-bit error by converting the one-hot syndromes to indices.
module fec_syndrome_classify
  import fec_pkg::*;
#(
  parameter  int WIDTH      = 4,
  parameter  int DEPTH      = 4,
  parameter  int CORRECT_EN = 1,
  localparam int ROW_W      = $clog2(DEPTH),
  localparam int COL_W      = $clog2(WIDTH)
) (
  input  logic [DEPTH-1:0] row_syn_i,
  input  logic [WIDTH-1:0] col_syn_i,
  output err_class_e       cls_o,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o
);

  logic             r_any, r_one, c_any, c_one;
  logic [ROW_W-1:0] row_idx;
  logic [COL_W-1:0] col_idx;

  // x & (x-1) clears the lowest set bit, so it is zero exactly when x has at most one bit set.
  assign r_any = |row_syn_i;
  assign c_any = |col_syn_i;
  assign r_one = r_any && ~|(row_syn_i & (row_syn_i - DEPTH'(1)));
  assign c_one = c_any && ~|(col_syn_i & (col_syn_i - WIDTH'(1)));

  // One-hot to index: OR together the indices of all set bits (exact when one-hot).
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    row_idx = '0;
    col_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (row_syn_i[i]) row_idx = row_idx | ROW_W'(i);
    end
    for (int j = 0; j < WIDTH; j++) begin
      if (col_syn_i[j]) col_idx = col_idx | COL_W'(j);
    end
  end

  // Error classification; location is reported only for a repairable data error.
  always_comb begin
    cls_o = UNCORR;
    row_o = '0;
    col_o = '0;
    if (!r_any && !c_any) begin
      cls_o = NONE;
    end else if (r_one && c_one) begin
      if (CORRECT_EN != 0) begin
        cls_o = DATA1;
        row_o = row_idx;
        col_o = col_idx;
      end
    end else if ((r_one && !c_any) || (!r_any && c_one)) begin
      cls_o = PAR1;
    end
  end

endmodule

// File: rtl/fec_stream_decoder.sv
// Row-serial 2D-parity FEC decoder: loads a block one row per beat plus a
// column-parity beat, classifies it, then drains the corrected rows.
module fec_stream_decoder
  import fec_pkg::*;
#(
  parameter  int WIDTH      = 4,
  parameter  int DEPTH      = 4,
  parameter  int ODD_PAR    = 0,
  parameter  int CORRECT_EN = 1,
  parameter  int CNT_W      = 16,
  localparam int ROW_W      = $clog2(DEPTH),
  localparam int COL_W      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             err_detected,
  output logic             err_corrected,
  output logic             err_uncorrectable,
  output logic [ROW_W-1:0] err_row,
  output logic [COL_W-1:0] err_col,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count
);

  localparam logic             ODD      = (ODD_PAR != 0);
  localparam logic [ROW_W-1:0] LAST_IDX = ROW_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] row_buf_q [DEPTH];
  logic [DEPTH-1:0] row_syn_q;
  logic [WIDTH-1:0] col_acc_q, col_syn_q;
  status_t          status_q, status_d;
  logic             fix_q;
  logic [CNT_W-1:0] corr_q, uncorr_q;

  err_class_e       cls;
  logic [ROW_W-1:0] cls_row;
  logic [COL_W-1:0] cls_col;
  logic             load_fire, colp_fire, in_check, draining;
  logic [WIDTH-1:0] fix_mask;
  logic             unused_status_bits;

  fec_syndrome_classify #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .CORRECT_EN(CORRECT_EN)
  ) u_classify (
    .row_syn_i(row_syn_q),
    .col_syn_i(col_syn_q),
    .cls_o    (cls),
    .row_o    (cls_row),
    .col_o    (cls_col)
  );

  assign load_fire = (state_q == LOAD) && in_valid;
  assign colp_fire = (state_q == COLP) && in_valid;
  assign in_check  = (state_q == CHECK);
  assign draining  = (state_q == DRAIN);

  // State and row-index register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = COLP;
          end else begin
            idx_d = idx_q + ROW_W'(1);
          end
        end
      end
      COLP: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CHECK;
      end
      CHECK: state_d = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            idx_d = idx_q + ROW_W'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Row storage; contents are only read after being written in the current block.
  always_ff @(posedge clk) begin
    // NOTE: the row buffer is deliberately not reset; idx/state reset makes stale rows unreachable.
    if (load_fire) row_buf_q[idx_q] <= in_data;
  end

  // Status derived from the classifier, latched once per block in CHECK.
  always_comb begin
    status_d               = '0;
    status_d.corrected     = (cls == DATA1) || (cls == PAR1);
    status_d.uncorrectable = (cls == UNCORR);
    status_d.detected      = status_d.corrected || status_d.uncorrectable;
    status_d.row           = IDX_MAX_W'(cls_row);
    status_d.col           = IDX_MAX_W'(cls_col);
  end

  // Syndrome accumulation and per-block status capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_syn_q <= '0;
      col_acc_q <= '0;
      col_syn_q <= '0;
      status_q  <= '0;
      fix_q     <= 1'b0;
    end else begin
      if (load_fire) begin
        row_syn_q[idx_q] <= ^in_data ^ in_par ^ ODD;
        col_acc_q        <= (idx_q == '0) ? in_data : (col_acc_q ^ in_data);
      end
      if (colp_fire) col_syn_q <= col_acc_q ^ in_data ^ {WIDTH{ODD}};
      if (in_check) begin
        status_q <= status_d;
        fix_q    <= (cls == DATA1);
      end
    end
  end

  // Saturating block counters; a clear overrides a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (in_check) begin
      if (status_d.corrected && (corr_q != '1)) corr_q <= corr_q + CNT_W'(1);
      if (status_d.uncorrectable && (uncorr_q != '1)) uncorr_q <= uncorr_q + CNT_W'(1);
    end
  end

  // Output mux: flip the located bit on the located row, zero everything outside DRAIN.
  assign fix_mask = (fix_q && (idx_q == status_q.row[ROW_W-1:0]))
                    ? (WIDTH'(1) << status_q.col[COL_W-1:0]) : '0;

  assign out_data          = draining ? (row_buf_q[idx_q] ^ fix_mask) : '0;
  assign out_last          = draining && (idx_q == LAST_IDX);
  assign err_detected      = draining && status_q.detected;
  assign err_corrected     = draining && status_q.corrected;
  assign err_uncorrectable = draining && status_q.uncorrectable;
  assign err_row           = draining ? status_q.row[ROW_W-1:0] : '0;
  assign err_col           = draining ? status_q.col[COL_W-1:0] : '0;
  assign corr_count        = corr_q;
  assign uncorr_count      = uncorr_q;

  // Upper index bits exist only to fit the widest decoder.
  assign unused_status_bits = ^{status_q.row, status_q.col};

endmodule

// File: tb/tb_fec_stream_decoder.sv
// Self-checking bench: two decoders (correcting/16-bit counters and
// detect-only/2-bit counters) share one input stream and are compared
// against a block-level parity model.
module tb_fec_stream_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_par = 1'b0;
  logic       out_ready = 1'b1;
  logic       cnt_clear = 1'b0;
  logic [3:0] in_data = '0;

  logic        in_ready1, out_valid1, out_last1, det1, cor1, unc1;
  logic [1:0]  row1, col1;
  logic [3:0]  data1;
  logic [15:0] cc1, uc1;

  logic        in_ready0, out_valid0, out_last0, det0, cor0, unc0;
  logic [1:0]  row0, col0;
  logic [3:0]  data0;
  logic [1:0]  cc0, uc0;

  int checks = 0;
  int errors = 0;

  // Expected values produced by the model for the block in flight.
  logic [3:0]  exp1 [4];
  logic [3:0]  exp0 [4];
  logic [2:0]  es1, es0;
  logic [1:0]  erow, ecol;
  logic [15:0] ecc1, euc1;
  logic [1:0]  ecc0, euc0;

  fec_stream_decoder #(.WIDTH(4), .DEPTH(4), .ODD_PAR(0), .CORRECT_EN(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .in_par(in_par), .out_valid(out_valid1), .out_ready(out_ready), .out_data(data1),
    .out_last(out_last1), .err_detected(det1), .err_corrected(cor1),
    .err_uncorrectable(unc1), .err_row(row1), .err_col(col1), .cnt_clear(cnt_clear),
    .corr_count(cc1), .uncorr_count(uc1)
  );

  fec_stream_decoder #(.WIDTH(4), .DEPTH(4), .ODD_PAR(0), .CORRECT_EN(0), .CNT_W(2)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .in_par(in_par), .out_valid(out_valid0), .out_ready(out_ready), .out_data(data0),
    .out_last(out_last0), .err_detected(det0), .err_corrected(cor0),
    .err_uncorrectable(unc0), .err_row(row0), .err_col(col0), .cnt_clear(cnt_clear),
    .corr_count(cc0), .uncorr_count(uc0)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [1:0] sat2(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

  // Idle: in_ready high, everything else zero, counters as modelled.
  task automatic check_idle(input string tag);
    check({tag, " d1 idle"}, {in_ready1, out_valid1, out_last1, det1, cor1, unc1, row1, col1, data1},
          {1'b1, 13'b0});
    check({tag, " d0 idle"}, {in_ready0, out_valid0, out_last0, det0, cor0, unc0, row0, col0, data0},
          {1'b1, 13'b0});
    check({tag, " d1 counters"}, {cc1, uc1}, {ecc1, euc1});
    check({tag, " d0 counters"}, {cc0, uc0}, {ecc0, euc0});
  endtask

  task automatic check_row(input string tag, input int k);
    check({tag, " d1 hs"}, {out_valid1, in_ready1, out_last1}, {1'b1, 1'b0, k == 3});
    check({tag, " d1 data"}, data1, exp1[k]);
    check({tag, " d1 status"}, {det1, cor1, unc1}, es1);
    if (es1[1]) check({tag, " d1 loc"}, {row1, col1}, {erow, ecol});
    check({tag, " d1 counters"}, {cc1, uc1}, {ecc1, euc1});
    check({tag, " d0 hs"}, {out_valid0, in_ready0, out_last0}, {1'b1, 1'b0, k == 3});
    check({tag, " d0 data"}, data0, exp0[k]);
    check({tag, " d0 status"}, {det0, cor0, unc0}, es0);
    if (es0[1]) check({tag, " d0 loc"}, {row0, col0}, 4'h0);
    check({tag, " d0 counters"}, {cc0, uc0}, {ecc0, euc0});
  endtask

  // Called at a negedge; waits (bounded) for in_ready, then transfers one beat.
  task automatic push(input logic [3:0] d, input logic p);
    int t = 0;
    while (!in_ready1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("push timeout", 32'(t), 32'd0);
    in_valid = 1'b1;
    in_data  = d;
    in_par   = p;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Send one block, predict results from the parity rules, and check the drain.
  task automatic run_block(input string tag, input logic [15:0] rows, input logic [3:0] pars,
                           input logic [3:0] colp, input int stall_row, input bit clr);
    int   nr, nc, rloc, cloc, t;
    logic bitv;
    bit   none, single, par_only;
    nr = 0; nc = 0; rloc = 0; cloc = 0;
    for (int r = 0; r < 4; r++) begin
      if (^rows[r*4 +: 4] ^ pars[r]) begin
        nr++;
        rloc = r;
      end
    end
    for (int c = 0; c < 4; c++) begin
      bitv = colp[c];
      for (int r = 0; r < 4; r++) bitv ^= rows[r*4 + c];
      if (bitv) begin
        nc++;
        cloc = c;
      end
    end
    none     = (nr + nc == 0);
    single   = (nr == 1) && (nc == 1);
    par_only = (nr + nc == 1);
    es1  = {!none, single || par_only, !none && !(single || par_only)};
    es0  = {!none, par_only, !none && !par_only};
    erow = single ? 2'(rloc) : 2'd0;
    ecol = single ? 2'(cloc) : 2'd0;
    for (int k = 0; k < 4; k++) begin
      exp0[k] = rows[k*4 +: 4];
      exp1[k] = rows[k*4 +: 4] ^ ((single && k == rloc) ? (4'b0001 << cloc) : 4'b0000);
    end
    if (clr) begin
      ecc1 = '0; euc1 = '0; ecc0 = '0; euc0 = '0;
    end else begin
      if (es1[1]) ecc1 = sat16(ecc1);
      if (es1[0]) euc1 = sat16(euc1);
      if (es0[1]) ecc0 = sat2(ecc0);
      if (es0[0]) euc0 = sat2(euc0);
    end

    for (int r = 0; r < 4; r++) push(rows[r*4 +: 4], pars[r]);
    push(colp, 1'($urandom));
    // One cycle after the column-parity beat: classifying, nothing out yet.
    check({tag, " check cycle"}, {out_valid1, in_ready1, out_valid0, in_ready0}, 4'b0000);
    if (clr) cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    check({tag, " first valid latency"}, out_valid1, 1'b1);

    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!out_valid1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) check({tag, " drain timeout"}, 32'(t), 32'd0);
      check_row($sformatf("%s row%0d", tag, k), k);
      if (k == stall_row) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check_row($sformatf("%s stall%0d row%0d", tag, s, k), k);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    check_idle({tag, " after drain"});
  endtask

  function automatic logic [3:0] colpar(input logic [15:0] rows);
    return rows[3:0] ^ rows[7:4] ^ rows[11:8] ^ rows[15:12];
  endfunction

  function automatic logic [3:0] rowpars(input logic [15:0] rows);
    logic [3:0] p;
    for (int r = 0; r < 4; r++) p[r] = ^rows[r*4 +: 4];
    return p;
  endfunction

  initial begin
    logic [15:0] rows;
    logic [3:0]  pars, colp;
    int          kind, b1, b2;

    ecc1 = '0; euc1 = '0; ecc0 = '0; euc0 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset held");
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset released");

    // Directed blocks.
    run_block("clean", 16'hFFFF, 4'b0000, 4'b0000, 9, 1'b0);
    run_block("data flip r3c0", 16'hEFFF, 4'b0000, 4'b0000, 9, 1'b0);
    run_block("row par flip", 16'hFFFF, 4'b1000, 4'b0000, 9, 1'b0);
    run_block("diagonal", 16'hEDB7, 4'b0000, 4'b0000, 9, 1'b0);
    run_block("col par flip", 16'h1234, rowpars(16'h1234), colpar(16'h1234) ^ 4'b0100, 9, 1'b0);
    run_block("backpressure", 16'h5A3C, rowpars(16'h5A3C), colpar(16'h5A3C), 1, 1'b0);

    // Reset after two beats of a block discards it.
    push(4'hA, 1'b0);
    push(4'h3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ecc1 = '0; euc1 = '0; ecc0 = '0; euc0 = '0;
    check_idle("mid-block reset");
    run_block("post reset clean", 16'h9C61, rowpars(16'h9C61), colpar(16'h9C61), 9, 1'b0);

    // Randomized blocks with random error injection and backpressure.
    for (int i = 0; i < 24; i++) begin
      rows = 16'($urandom);
      pars = rowpars(rows);
      colp = colpar(rows);
      kind = $urandom_range(0, 4);
      case (kind)
        1: rows[$urandom_range(0, 15)] ^= 1'b1;
        2: pars[$urandom_range(0, 3)] ^= 1'b1;
        3: colp[$urandom_range(0, 3)] ^= 1'b1;
        4: begin
          b1 = $urandom_range(0, 15);
          b2 = (b1 + 1 + $urandom_range(0, 14)) % 16;
          rows[b1] ^= 1'b1;
          rows[b2] ^= 1'b1;
        end
        default: ;
      endcase
      run_block($sformatf("rand%0d k%0d", i, kind), rows, pars, colp, $urandom_range(0, 7), 1'b0);
    end

    // Standalone clear, then saturation of the narrow counter.
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    ecc1 = '0; euc1 = '0; ecc0 = '0; euc0 = '0;
    check_idle("counter clear");
    for (int i = 0; i < 5; i++) run_block($sformatf("sat%0d", i), 16'hEDB7, 4'b0000, 4'b0000, 9, 1'b0);
    check("d0 uncorr saturated", uc0, 2'd3);
    check("d1 uncorr count", uc1, 16'd5);

    // Clear coincident with an increment wins.
    run_block("clear vs inc", 16'hEDB7, 4'b0000, 4'b0000, 9, 1'b1);
    check("clear wins d0", uc0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
